fft_frame_loader: RTL and testbench

Serial-to-parallel input stage placed directly upstream of `fft_N_point_core`. It accepts one sample per cycle over a valid/ready stream and assembles each group of N_POINT samples into a frame. Each frame is stored in bit-reversed order, as the decimation-in-time butterfly network expects. Completed frames are presented to the core as the parallel vector `m_data[N_POINT]` through a ping-pong (two-bank) buffer, so input streaming continues while the previous frame is held for the core.

---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_frame_bank.sv | 31 +++
 rtl/fft_frame_loader.sv | 105 ++++++++++
 tb/tb_fft_frame_loader.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT helpers: index-width helper, bit reversal, and the common sample type.
package fft_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic int idx_bits(input int n_point);
    return $clog2(n_point);
  endfunction

  // Reverse the low 'bits' bits of idx; upper bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int bits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < bits) r[5'(i)] = idx[5'(bits - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One N_POINT-word frame bank: single write port, every word visible in parallel.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINT    = 16,
  localparam int IDX_W     = idx_bits(N_POINT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata [N_POINT]
);

  logic [DATA_WIDTH-1:0] mem_q [N_POINT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_POINT; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    for (int i = 0; i < N_POINT; i++) rdata[i] = mem_q[i];
  end

endmodule

// File: rtl/fft_frame_loader.sv
// Serial-to-parallel ping-pong frame loader feeding the FFT core.
// FFT_LOADER_BITREV_EN: store samples at bit-reversed addresses (DIT order); else natural order.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINT    = 16,
  localparam int IDX_W     = idx_bits(N_POINT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_sof,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data [N_POINT],
  output logic                  sync_err
);

  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] wr_idx_q,  wr_idx_d;
  logic [1:0]       full_q,    full_d;
  logic             sync_err_q, sync_err_d;

  logic             accept, resync, last, release_frm;
  logic [IDX_W-1:0] idx_eff, waddr;
  logic [DATA_WIDTH-1:0] rdata0 [N_POINT];
  logic [DATA_WIDTH-1:0] rdata1 [N_POINT];

  assign s_ready     = !rst && !full_q[wr_bank_q];
  assign m_valid     = full_q[rd_bank_q];
  assign sync_err    = sync_err_q;
  assign accept      = s_valid && s_ready;
  assign release_frm = m_valid && m_ready;
  // A mid-frame sof restarts the same bank with this beat as index 0.
  assign resync      = accept && s_sof && (wr_idx_q != '0);
  assign idx_eff     = resync ? '0 : wr_idx_q;
  assign last        = accept && !resync && (wr_idx_q == IDX_W'(N_POINT - 1));

`ifdef FFT_LOADER_BITREV_EN
  assign waddr = IDX_W'(bitrev(32'(idx_eff), IDX_W));
`else
  assign waddr = idx_eff;
`endif

  always_comb begin
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_idx_d   = wr_idx_q;
    sync_err_d = resync;
    // Release and fill always target different banks, so both updates apply.
    if (release_frm) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
    if (accept) wr_idx_d = resync ? IDX_W'(1) : wr_idx_q + 1'b1;
    if (last) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = !wr_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      sync_err_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_idx_q   <= wr_idx_d;
      sync_err_q <= sync_err_d;
    end
  end

  fft_frame_bank #(.DATA_WIDTH(DATA_WIDTH), .N_POINT(N_POINT)) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && !wr_bank_q),
    .waddr (waddr),
    .wdata (s_data),
    .rdata (rdata0)
  );

  fft_frame_bank #(.DATA_WIDTH(DATA_WIDTH), .N_POINT(N_POINT)) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && wr_bank_q),
    .waddr (waddr),
    .wdata (s_data),
    .rdata (rdata1)
  );

  always_comb begin
    for (int i = 0; i < N_POINT; i++) m_data[i] = rd_bank_q ? rdata1[i] : rdata0[i];
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed + randomized bench for fft_frame_loader against a queue-based frame model.
module tb_fft_frame_loader;

  localparam int DW = 16;
  localparam int N  = 16;

  typedef logic [DW-1:0] frame_t [N];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_sof = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data [N];
  logic          sync_err;

  int checks = 0;
  int passed = 0;
  int serr_seen = 0;

  // Model: completed frames awaiting the consumer, and the frame being gathered.
  frame_t        pending [$];
  logic [DW-1:0] cur [$];
  bit            known = 0;
  bit            mem_zero = 0;
  bit            exp_serr = 0;

  always #5 clk = ~clk;

  fft_frame_loader #(.DATA_WIDTH(DW), .N_POINT(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_sof    (s_sof),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .sync_err (sync_err)
  );

  function automatic int addr_of(input int k);
`ifdef FFT_LOADER_BITREV_EN
    int r;
    r = 0;
    for (int b = 0; b < 4; b++) if ((k >> b) & 1) r = r + (1 << (3 - b));
    return r;
`else
    return k;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock cycle: drive, check outputs against the model, then advance the model at the edge.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit sof, input bit mr, input bit r);
    bit     exp_rdy, acc, rel;
    frame_t f;
    s_valid = v; s_data = d; s_sof = sof; m_ready = mr; rst = r;
    #1;
    exp_rdy = !r && (pending.size() < 2);
    if (sync_err === 1'b1) serr_seen++;
    if (known) begin
      chk("s_ready", 32'(s_ready), 32'(exp_rdy));
      chk("m_valid", 32'(m_valid), 32'(pending.size() > 0));
      chk("sync_err", 32'(sync_err), 32'(exp_serr));
      if (pending.size() > 0) begin
        for (int i = 0; i < N; i++) chk("m_data", 32'(m_data[i]), 32'(pending[0][i]));
      end else if (mem_zero) begin
        for (int i = 0; i < N; i++) chk("m_data_zero", 32'(m_data[i]), 32'd0);
      end
    end
    @(posedge clk);
    if (r) begin
      known = 1; mem_zero = 1; exp_serr = 0;
      pending.delete(); cur.delete();
    end else if (known) begin
      acc = v && exp_rdy;
      rel = (pending.size() > 0) && mr;
      exp_serr = 0;
      if (rel) pending.delete(0);
      if (acc) begin
        mem_zero = 0;
        if (sof && cur.size() != 0) begin
          cur.delete();
          exp_serr = 1;
        end
        cur.push_back(d);
        if (cur.size() == N) begin
          for (int k = 0; k < N; k++) f[addr_of(k)] = cur[k];
          pending.push_back(f);
          cur.delete();
        end
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] e4, e8, e12;
    // Reset
    cyc(0, '0, 0, 0, 1);
    cyc(0, '0, 0, 0, 1);
    cyc(1, 16'h1234, 1, 0, 1);

    // Bit reversal: samples 0..15
    for (int k = 0; k < N; k++) cyc(1, DW'(k), k == 0, 1, 0);
`ifdef FFT_LOADER_BITREV_EN
    e4 = 2; e8 = 1; e12 = 3;
`else
    e4 = 4; e8 = 8; e12 = 12;
`endif
    chk("bitrev_valid", 32'(m_valid), 32'd1);
    chk("bitrev_d0", 32'(m_data[0]), 32'd0);
    chk("bitrev_d4", 32'(m_data[4]), e4);
    chk("bitrev_d8", 32'(m_data[8]), e8);
    chk("bitrev_d12", 32'(m_data[12]), e12);
    chk("bitrev_d15", 32'(m_data[15]), 32'd15);
    cyc(0, '0, 0, 1, 0);

    // Back-pressure: two frames with no consumer, then extra rejected beats
    for (int k = 0; k < 2 * N; k++) cyc(1, DW'($urandom), (k % N) == 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(1, DW'($urandom), 0, 0, 0);
    cyc(0, '0, 0, 1, 0);
    chk("bp_ready_after_release", 32'(s_ready), 32'd1);
    cyc(0, '0, 0, 0, 0);
    cyc(0, '0, 0, 1, 0);

    // Resync: sof on beat 5 discards the partial frame
    serr_seen = 0;
    for (int k = 0; k < 5; k++) cyc(1, DW'(16'hdead), k == 0, 1, 0);
    for (int k = 0; k < N; k++) cyc(1, DW'(16'h100 + k), k == 0, 1, 0);
    cyc(0, '0, 0, 1, 0);
    cyc(0, '0, 0, 1, 0);
    chk("resync_pulses", 32'(serr_seen), 32'd1);

    // Reset mid-frame, then a clean frame
    for (int k = 0; k < 7; k++) cyc(1, DW'($urandom), k == 0, 1, 0);
    cyc(1, DW'($urandom), 0, 1, 1);
    cyc(1, DW'($urandom), 0, 1, 1);
    for (int k = 0; k < N; k++) cyc(1, DW'(16'h200 + k), k == 0, 1, 0);
    cyc(0, '0, 0, 1, 0);

    // Continuous streaming at full rate
    for (int k = 0; k < 4 * N; k++) cyc(1, DW'($urandom), (k % N) == 0, 1, 0);
    cyc(0, '0, 0, 1, 0);
    cyc(0, '0, 0, 1, 0);

    // Randomized traffic with occasional sof and reset
    for (int k = 0; k < 500; k++)
      cyc($urandom_range(3) != 0, DW'($urandom), $urandom_range(19) == 0,
          $urandom_range(1) == 1, $urandom_range(99) == 0);
    for (int k = 0; k < 4; k++) cyc(0, '0, 0, 1, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
